// File: rtl/background_fill_engine.sv
// Raster-order framebuffer background filler with NUM_BANDS programmable horizontal color bands.
// Define BG_DITHER_EN to add a checkerboard transition in the last two rows of each band.
module background_fill_engine #(
    parameter int BUFFER_WIDTH      = 160,
    parameter int BUFFER_HEIGHT     = 120,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
    parameter int NUM_BANDS         = 4,
    parameter int COLOR_WIDTH       = 16,
    parameter int END_WIDTH         = $clog2(BUFFER_HEIGHT)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               draw_start_i,
    input  logic                               abort_i,
    input  logic [NUM_BANDS*COLOR_WIDTH-1:0]   band_color_i,
    input  logic [NUM_BANDS*END_WIDTH-1:0]     band_end_y_i,
    output logic                               busy_o,
    output logic                               draw_done_o,
    output logic                               write_en_o,
    input  logic                               write_ready_i,
    output logic [BUFFER_ADDR_WIDTH-1:0]       write_addr_o,
    output logic [COLOR_WIDTH-1:0]             write_data_o
);

    localparam int XW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
    localparam int YW = END_WIDTH;
    localparam int CW = COLOR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       state_q;
    logic [XW-1:0]                x_q, x_d;
    logic [YW-1:0]                y_q, y_d;
    logic [BUFFER_ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]                data_q, data_d;
    logic [NUM_BANDS*CW-1:0]      colors_q;
    logic [NUM_BANDS*YW-1:0]      ends_q;
    logic                         busy_q, done_q, wen_q;
    logic                         last_pixel;
    logic [YW-1:0]                py;
    logic [NUM_BANDS*CW-1:0]      col_src;
    logic [NUM_BANDS*YW-1:0]      end_src;
    int                           band;
`ifdef BG_DITHER_EN
    logic [XW-1:0]                px;
`endif

    // Color of the pixel presented next: (0,0) from the live inputs at start, else the successor pixel.
    always_comb begin
        last_pixel = (x_q == XW'(BUFFER_WIDTH - 1)) && (y_q == YW'(BUFFER_HEIGHT - 1));
        if (x_q == XW'(BUFFER_WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
        end else begin
            x_d = x_q + 1'b1;
            y_d = y_q;
        end

        if (state_q == S_IDLE) begin
            py      = '0;
            col_src = band_color_i;
            end_src = band_end_y_i;
        end else begin
            py      = y_d;
            col_src = colors_q;
            end_src = ends_q;
        end

        band = NUM_BANDS - 1;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (py <= end_src[i*YW +: YW]) band = i;
        end
        data_d = col_src[band*CW +: CW];

`ifdef BG_DITHER_EN
        px = (state_q == S_IDLE) ? '0 : x_d;
        if ((band < NUM_BANDS - 1) && (px[0] ^ py[0]) &&
            ((py == end_src[band*YW +: YW]) ||
             ({1'b0, py} + 1'b1 == {1'b0, end_src[band*YW +: YW]}))) begin
            data_d = col_src[(band+1)*CW +: CW];
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            colors_q <= '0;
            ends_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wen_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (draw_start_i) begin
                        colors_q <= band_color_i;
                        ends_q   <= band_end_y_i;
                        x_q      <= '0;
                        y_q      <= '0;
                        addr_q   <= '0;
                        data_q   <= data_d;
                        wen_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (abort_i) begin
                        wen_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (write_ready_i) begin
                        if (last_pixel) begin
                            wen_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            x_q    <= x_d;
                            y_q    <= y_d;
                            addr_q <= addr_q + 1'b1;
                            data_q <= data_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    wen_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign draw_done_o  = done_q;
    assign write_en_o   = wen_q;
    assign write_addr_o = addr_q;
    assign write_data_o = data_q;

endmodule

// File: tb/tb_background_fill_engine.sv
// Self-checking bench for background_fill_engine: every accepted write is compared with a
// pixel-index model of the band rules; covers back-pressure, abort, mid-fill reset and band edge cases.
module tb_background_fill_engine;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int NB = 4;
    localparam int CW = 16;
    localparam int YW = 7;
    localparam int AW = 15;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              draw_start = 1'b0;
    logic              abort_s = 1'b0;
    logic              write_ready = 1'b0;
    logic [NB*CW-1:0]  band_color = '0;
    logic [NB*YW-1:0]  band_end_y = '0;
    logic              busy, draw_done, write_en;
    logic [AW-1:0]     write_addr;
    logic [CW-1:0]     write_data;

    logic [15:0] m_color [NB];
    int          m_end   [NB];
    logic [15:0] seen    [W*H];
    int errors, checks, k, cyc, stalls, done_cnt, done_cyc;

    background_fill_engine #(
        .BUFFER_WIDTH(W), .BUFFER_HEIGHT(H), .NUM_BANDS(NB), .COLOR_WIDTH(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .draw_start_i(draw_start), .abort_i(abort_s),
        .band_color_i(band_color), .band_end_y_i(band_end_y),
        .busy_o(busy), .draw_done_o(draw_done), .write_en_o(write_en),
        .write_ready_i(write_ready), .write_addr_o(write_addr), .write_data_o(write_data)
    );

    always #5 clk = ~clk;

    // Expected color of the idx-th pixel in raster order.
    function automatic logic [15:0] exp_color(input int idx);
        int x, y, b;
        x = idx % W;
        y = idx / W;
        b = NB - 1;
        for (int i = 0; i < NB; i++) begin
            if (y <= m_end[i]) begin
                b = i;
                break;
            end
        end
`ifdef BG_DITHER_EN
        if (b < NB - 1 && (y == m_end[b] || y == m_end[b] - 1) && ((x + y) % 2 == 1))
            return m_color[b+1];
`endif
        return m_color[b];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, draw_done}, 0);
        check({tag, "_wen"},  {31'd0, write_en}, 0);
        check({tag, "_addr"}, {17'd0, write_addr}, 0);
        check({tag, "_data"}, {16'd0, write_data}, 0);
    endtask

    task automatic start_fill(input logic with_abort);
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            band_color[i*CW +: CW] = m_color[i];
            band_end_y[i*YW +: YW] = YW'(m_end[i]);
        end
        draw_start  = 1'b1;
        abort_s     = with_abort;
        write_ready = 1'b1;
        @(negedge clk);
        draw_start = 1'b0;
        abort_s    = 1'b0;
        band_color = {$urandom, $urandom};
        band_end_y = 28'($urandom);
    endtask

    // kind: 0 = run to completion, 1 = abort at stop_k, 2 = async reset at stop_k
    task automatic run_fill(input bit rnd, input int kind, input int stop_k);
        int r;
        bit fin;
        k = 0; cyc = 1; stalls = 0; done_cnt = 0; done_cyc = 0; fin = 0;
        for (int i = 0; i < W*H; i++) seen[i] = '0;
        check("start_wen",  {31'd0, write_en}, 1);
        check("start_busy", {31'd0, busy}, 1);
        while (!fin && cyc < 3*W*H) begin
            if (write_en) begin
                check("addr", {17'd0, write_addr}, k);
                check("data", {16'd0, write_data}, {16'd0, exp_color(k)});
                if (kind == 2 && k == stop_k) begin
                    rstn = 1'b0;
                    #1;
                    check_all_zero("reset_mid");
                    @(negedge clk);
                    rstn = 1'b1;
                    fin = 1;
                end else begin
                    r = rnd ? int'($urandom_range(0, 1)) : 1;
                    write_ready = r[0];
                    draw_start  = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
                    if (kind == 1 && k == stop_k) abort_s = 1'b1;
                    if (r != 0) begin
                        seen[k] = write_data;
                        k++;
                    end else begin
                        stalls++;
                    end
                    if (abort_s) begin
                        @(negedge clk);
                        abort_s = 1'b0;
                        draw_start = 1'b0;
                        check("abort_wen",  {31'd0, write_en}, 0);
                        check("abort_busy", {31'd0, busy}, 0);
                        for (int i = 0; i < 20; i++) begin
                            check("abort_no_done", {31'd0, draw_done}, 0);
                            @(negedge clk);
                        end
                        fin = 1;
                    end
                end
            end else begin
                draw_start  = 1'b0;
                write_ready = 1'($urandom_range(0, 1));
                if (draw_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_busy", {31'd0, busy}, 1);
                end else if (done_cnt > 0) begin
                    check("after_done_busy", {31'd0, busy}, 0);
                    fin = 1;
                end else begin
                    check("wen_dropped_early", {31'd0, write_en}, 1);
                    fin = 1;
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("fill_terminated", {31'd0, fin}, 1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Two effective bands, full back-pressure-free fill.
        m_color = '{16'h055F, 16'h8410, 16'h1234, 16'h5678};
        m_end   = '{59, 119, 119, 119};
        start_fill(1'b0);
        run_fill(1'b0, 0, 0);
        check("A_done_count", done_cnt, 1);
        check("A_done_cycle", done_cyc, W*H + 1);
        check("A_pixels", k, W*H);
        check("A_row59", {16'd0, seen[59*W+5]}, 32'h055F);
        check("A_row60", {16'd0, seen[60*W+7]}, 32'h8410);
        check("A_last",  {16'd0, seen[W*H-1]}, 32'h8410);

        // Random bands and 50% write_ready with stray draw_start pulses.
        for (int i = 0; i < NB; i++) begin
            m_color[i] = 16'($urandom);
            m_end[i]   = int'($urandom_range(0, H - 1));
        end
        for (int i = 0; i < NB; i++)
            for (int j = 0; j < NB - 1 - i; j++)
                if (m_end[j] > m_end[j+1]) begin
                    int t;
                    t = m_end[j]; m_end[j] = m_end[j+1]; m_end[j+1] = t;
                end
        start_fill(1'b0);
        run_fill(1'b1, 0, 0);
        check("B_done_count", done_cnt, 1);
        check("B_done_cycle", done_cyc, W*H + stalls + 1);
        check("B_pixels", k, W*H);

        // Empty band 1; start together with abort; abort at pixel 5000.
        m_color = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
        m_end   = '{10, 10, 50, 119};
        start_fill(1'b1);
        run_fill(1'b0, 1, 5000);
        check("C_row10", {16'd0, seen[10*W+2]}, {16'd0, m_color[0]});
        check("C_row11", {16'd0, seen[11*W+4]}, {16'd0, m_color[2]});

        // Restart after abort; rows past the last end fall into band 3; reset mid-fill.
        m_color = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        m_end   = '{10, 20, 30, 40};
        start_fill(1'b0);
        run_fill(1'b0, 2, 7000);
        check("D_row41", {16'd0, seen[41*W]},   {16'd0, m_color[3]});
        check("D_row43", {16'd0, seen[43*W+9]}, {16'd0, m_color[3]});
        check("D_row40", {16'd0, seen[40*W+2]}, {16'd0, m_color[3]});

        // Fill from address 0 after reset release, then reset at pixel 300.
        start_fill(1'b0);
        run_fill(1'b1, 2, 300);
        @(negedge clk);
        check_all_zero("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
